// File: rtl/motion_scheduler_pkg.sv
// Shared encodings for the motion scheduler: steering requests, H-bridge directions
// and the display mode of the sequencing FSM.
package motion_scheduler_pkg;

    typedef enum logic [1:0] {
        STEER_STOP     = 2'b00,
        STEER_RIGHT    = 2'b01,
        STEER_LEFT     = 2'b10,
        STEER_STRAIGHT = 2'b11
    } steer_e;

    typedef enum logic [1:0] {
        DIR_COAST = 2'b00,
        DIR_REV   = 2'b01,
        DIR_FWD   = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RAMP  = 2'b01,
        MODE_RUN   = 2'b10,
        MODE_BRAKE = 2'b11
    } mode_e;

endpackage

// File: rtl/pwm_ramp_channel.sv
// One wheel: duty register that slews toward its target on each ramp tick,
// saturating exactly at the target, plus the registered PWM compare.
module pwm_ramp_channel #(
    parameter int unsigned PWM_W     = 10,
    parameter int unsigned RAMP_STEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] cnt,
    input  logic             tick,
    input  logic             clear,
    input  logic [PWM_W-1:0] target,
    output logic [PWM_W-1:0] duty,
    output logic             pwm
);

    localparam logic [PWM_W:0]   STEP_WIDE_C = (PWM_W+1)'(RAMP_STEP);
    localparam logic [PWM_W-1:0] STEP_C      = PWM_W'(RAMP_STEP);

    logic [PWM_W-1:0] duty_r;
    logic [PWM_W-1:0] duty_next_s;
    logic [PWM_W:0]   up_gap_s;
    logic [PWM_W:0]   down_gap_s;
    logic             pwm_r;

    // Next duty one step closer to the target; gaps are taken one bit wider so nothing wraps.
    always_comb begin
        up_gap_s    = {1'b0, target} - {1'b0, duty_r};
        down_gap_s  = {1'b0, duty_r} - {1'b0, target};
        duty_next_s = duty_r;
        if (duty_r < target) begin
            if (up_gap_s > STEP_WIDE_C) begin
                duty_next_s = duty_r + STEP_C;
            end else begin
                duty_next_s = target;
            end
        end else if (duty_r > target) begin
            if (down_gap_s > STEP_WIDE_C) begin
                duty_next_s = duty_r - STEP_C;
            end else begin
                duty_next_s = target;
            end
        end else begin
            duty_next_s = duty_r;
        end
    end

    // Duty register and PWM output; clear drops both to zero on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_r <= {PWM_W{1'b0}};
            pwm_r  <= 1'b0;
        end else if (clear) begin
            duty_r <= {PWM_W{1'b0}};
            pwm_r  <= 1'b0;
        end else begin
            if (tick) begin
                duty_r <= duty_next_s;
            end else begin
                duty_r <= duty_r;
            end
            pwm_r <= (cnt < duty_r);
        end
    end

    assign duty = duty_r;
    assign pwm  = pwm_r;

endmodule

// File: rtl/motion_scheduler.sv
// Motion scheduler top: start/stop > debounced obstacle > tracker arbitration driving two
// ramped PWM wheel channels. Define REVERSE_PIVOT_EN to run the inner wheel in reverse on turns.
module motion_scheduler
    import motion_scheduler_pkg::*;
#(
    parameter int unsigned PWM_W      = 10,
    parameter int unsigned SPEED_FAST = 1000,
    parameter int unsigned SPEED_SLOW = 600,
    parameter int unsigned RAMP_STEP  = 8,
    parameter int unsigned RAMP_DIV   = 100000,
    parameter int unsigned OBST_DEB   = 1000000,
    parameter int unsigned BRAKE_MIN  = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_move,
    input  logic [1:0] track_state,
    input  logic       obstacle,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic [1:0] mode
);

    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEB_W = $clog2(OBST_DEB + 1);
    localparam int unsigned BRK_W = $clog2(BRAKE_MIN + 1);

    localparam logic [PWM_W-1:0] FAST_C     = PWM_W'(SPEED_FAST);
    localparam logic [PWM_W-1:0] SLOW_C     = PWM_W'(SPEED_SLOW);
    localparam logic [PWM_W-1:0] ZERO_C     = {PWM_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(RAMP_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST_C = DEB_W'(OBST_DEB - 1);
    localparam logic [BRK_W-1:0] BRK_MIN_C  = BRK_W'(BRAKE_MIN);
`ifdef REVERSE_PIVOT_EN
    localparam dir_e INNER_DIR_C = DIR_REV;
`else
    localparam dir_e INNER_DIR_C = DIR_FWD;
`endif

    logic [PWM_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             obst_deb_r;
    logic [BRK_W-1:0] brake_cnt_r;
    mode_e            state_r;
    mode_e            next_state_s;
    dir_e             left_dir_r;
    dir_e             right_dir_r;
    dir_e             left_tdir_s;
    dir_e             right_tdir_s;
    logic [PWM_W-1:0] left_tgt_s;
    logic [PWM_W-1:0] right_tgt_s;
    logic [PWM_W-1:0] left_eff_s;
    logic [PWM_W-1:0] right_eff_s;
    logic [PWM_W-1:0] left_duty_s;
    logic [PWM_W-1:0] right_duty_s;
    logic             at_target_s;
    logic             clear_s;

    // Free-running PWM counter and ramp-tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {PWM_W{1'b0}};
            div_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + PWM_W'(1);
            if (tick_s) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end
    end

    assign tick_s = (div_r == DIV_LAST_C);

    // Obstacle debounce: raw level must disagree for OBST_DEB consecutive cycles to flip.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_cnt_r  <= {DEB_W{1'b0}};
            obst_deb_r <= 1'b0;
        end else if (obstacle != obst_deb_r) begin
            if (deb_cnt_r == DEB_LAST_C) begin
                obst_deb_r <= ~obst_deb_r;
                deb_cnt_r  <= {DEB_W{1'b0}};
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
        end else begin
            deb_cnt_r <= {DEB_W{1'b0}};
        end
    end

    // Steering request to per-wheel target duty and direction.
    always_comb begin
        left_tgt_s   = ZERO_C;
        right_tgt_s  = ZERO_C;
        left_tdir_s  = DIR_COAST;
        right_tdir_s = DIR_COAST;
        case (steer_e'(track_state))
            STEER_STRAIGHT: begin
                left_tgt_s   = FAST_C;
                right_tgt_s  = FAST_C;
                left_tdir_s  = DIR_FWD;
                right_tdir_s = DIR_FWD;
            end
            STEER_LEFT: begin
                left_tgt_s   = SLOW_C;
                right_tgt_s  = FAST_C;
                left_tdir_s  = INNER_DIR_C;
                right_tdir_s = DIR_FWD;
            end
            STEER_RIGHT: begin
                left_tgt_s   = FAST_C;
                right_tgt_s  = SLOW_C;
                left_tdir_s  = DIR_FWD;
                right_tdir_s = INNER_DIR_C;
            end
            default: begin
                left_tgt_s   = ZERO_C;
                right_tgt_s  = ZERO_C;
                left_tdir_s  = DIR_COAST;
                right_tdir_s = DIR_COAST;
            end
        endcase
    end

    // A wheel whose direction must change is first ramped to zero before it flips.
    always_comb begin
        left_eff_s  = (left_dir_r == left_tdir_s) ? left_tgt_s : ZERO_C;
        right_eff_s = (right_dir_r == right_tdir_s) ? right_tgt_s : ZERO_C;
        at_target_s = (left_dir_r == left_tdir_s) && (left_duty_s == left_tgt_s) &&
                      (right_dir_r == right_tdir_s) && (right_duty_s == right_tgt_s);
    end

    // Next-state arbitration: start/stop first, then obstacle, then tracker.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MODE_IDLE: begin
                if (start_move) begin
                    next_state_s = MODE_RAMP;
                end else begin
                    next_state_s = MODE_IDLE;
                end
            end
            MODE_RAMP: begin
                if (!start_move) begin
                    next_state_s = MODE_IDLE;
                end else if (obst_deb_r) begin
                    next_state_s = MODE_BRAKE;
                end else if (at_target_s) begin
                    next_state_s = MODE_RUN;
                end else begin
                    next_state_s = MODE_RAMP;
                end
            end
            MODE_RUN: begin
                if (!start_move) begin
                    next_state_s = MODE_IDLE;
                end else if (obst_deb_r) begin
                    next_state_s = MODE_BRAKE;
                end else if (!at_target_s && (steer_e'(track_state) != STEER_STOP)) begin
                    next_state_s = MODE_RAMP;
                end else begin
                    next_state_s = MODE_RUN;
                end
            end
            MODE_BRAKE: begin
                if (!start_move) begin
                    next_state_s = MODE_IDLE;
                end else if ((brake_cnt_r >= BRK_MIN_C) && !obst_deb_r) begin
                    next_state_s = MODE_RAMP;
                end else begin
                    next_state_s = MODE_BRAKE;
                end
            end
            default: begin
                next_state_s = MODE_IDLE;
            end
        endcase
        clear_s = (next_state_s == MODE_IDLE) || (next_state_s == MODE_BRAKE);
    end

    // State, brake timer and registered wheel directions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= MODE_IDLE;
            brake_cnt_r <= {BRK_W{1'b0}};
            left_dir_r  <= DIR_COAST;
            right_dir_r <= DIR_COAST;
        end else begin
            state_r <= next_state_s;
            if (state_r != MODE_BRAKE) begin
                brake_cnt_r <= {BRK_W{1'b0}};
            end else if (brake_cnt_r < BRK_MIN_C) begin
                brake_cnt_r <= brake_cnt_r + BRK_W'(1);
            end else begin
                brake_cnt_r <= brake_cnt_r;
            end
            if (clear_s) begin
                left_dir_r  <= DIR_COAST;
                right_dir_r <= DIR_COAST;
            end else begin
                if ((left_dir_r != left_tdir_s) && (left_duty_s == ZERO_C)) begin
                    left_dir_r <= left_tdir_s;
                end else begin
                    left_dir_r <= left_dir_r;
                end
                if ((right_dir_r != right_tdir_s) && (right_duty_s == ZERO_C)) begin
                    right_dir_r <= right_tdir_s;
                end else begin
                    right_dir_r <= right_dir_r;
                end
            end
        end
    end

    pwm_ramp_channel #(
        .PWM_W     (PWM_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .cnt    (cnt_r),
        .tick   (tick_s),
        .clear  (clear_s),
        .target (left_eff_s),
        .duty   (left_duty_s),
        .pwm    (left_pwm)
    );

    pwm_ramp_channel #(
        .PWM_W     (PWM_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .cnt    (cnt_r),
        .tick   (tick_s),
        .clear  (clear_s),
        .target (right_eff_s),
        .duty   (right_duty_s),
        .pwm    (right_pwm)
    );

    assign left_dir  = left_dir_r;
    assign right_dir = right_dir_r;
    assign mode      = state_r;

endmodule

// File: tb/tb_motion_scheduler.sv
// Self-checking bench for motion_scheduler with small parameters: directed scenarios with
// fixed expectations plus randomized stimulus against a cycle-level behavioural model.
module tb_motion_scheduler;

    localparam int PWM_W = 4;
    localparam int FAST  = 12;
    localparam int SLOW  = 6;
    localparam int STEP  = 4;
    localparam int DIV   = 2;
    localparam int DEB   = 3;
    localparam int BMIN  = 10;
    localparam int FWD   = 2;
`ifdef REVERSE_PIVOT_EN
    localparam int INNER = 1;
`else
    localparam int INNER = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_move = 1'b0;
    logic [1:0] track_state = 2'b00;
    logic       obstacle = 1'b0;
    logic       left_pwm;
    logic       right_pwm;
    logic [1:0] left_dir;
    logic [1:0] right_dir;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state (plain integers)
    int m_state, m_cnt, m_div, m_debc, m_brake;
    bit m_deb;
    int m_duty[2];
    int m_dir[2];
    int m_pwm[2];

    motion_scheduler #(
        .PWM_W(PWM_W), .SPEED_FAST(FAST), .SPEED_SLOW(SLOW), .RAMP_STEP(STEP),
        .RAMP_DIV(DIV), .OBST_DEB(DEB), .BRAKE_MIN(BMIN)
    ) dut (
        .clk(clk), .reset(reset), .start_move(start_move), .track_state(track_state),
        .obstacle(obstacle), .left_pwm(left_pwm), .right_pwm(right_pwm),
        .left_dir(left_dir), .right_dir(right_dir), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_div = 0; m_debc = 0; m_brake = 0; m_deb = 1'b0;
        for (int w = 0; w < 2; w++) begin
            m_duty[w] = 0; m_dir[w] = 0; m_pwm[w] = 0;
        end
    endtask

    task automatic model_step();
        int td[2]; int tdir[2]; int nd[2]; int ndir[2]; int np[2];
        int eff; int nstate; bit tick; bit met; bit zero;
        case (track_state)
            2'b11:   begin td[0] = FAST; tdir[0] = FWD;   td[1] = FAST; tdir[1] = FWD;   end
            2'b10:   begin td[0] = SLOW; tdir[0] = INNER; td[1] = FAST; tdir[1] = FWD;   end
            2'b01:   begin td[0] = FAST; tdir[0] = FWD;   td[1] = SLOW; tdir[1] = INNER; end
            default: begin td[0] = 0;    tdir[0] = 0;     td[1] = 0;    tdir[1] = 0;     end
        endcase
        tick = (m_div == DIV - 1);
        met = 1'b1;
        for (int w = 0; w < 2; w++)
            if (m_dir[w] != tdir[w] || m_duty[w] != td[w]) met = 1'b0;
        if (m_state == 0)       nstate = start_move ? 1 : 0;
        else if (!start_move)   nstate = 0;
        else if (m_state == 3)  nstate = (m_brake >= BMIN && !m_deb) ? 1 : 3;
        else if (m_deb)         nstate = 3;
        else if (m_state == 1)  nstate = met ? 2 : 1;
        else                    nstate = (!met && track_state != 2'b00) ? 1 : 2;
        zero = (nstate == 0 || nstate == 3);
        for (int w = 0; w < 2; w++) begin
            eff = (m_dir[w] == tdir[w]) ? td[w] : 0;
            if (zero) begin
                nd[w] = 0; np[w] = 0; ndir[w] = 0;
            end else begin
                np[w] = (m_cnt < m_duty[w]) ? 1 : 0;
                nd[w] = m_duty[w];
                if (tick) begin
                    if (m_duty[w] < eff) nd[w] = (m_duty[w] + STEP < eff) ? m_duty[w] + STEP : eff;
                    else                 nd[w] = (m_duty[w] - STEP > eff) ? m_duty[w] - STEP : eff;
                end
                ndir[w] = (m_dir[w] != tdir[w] && m_duty[w] == 0) ? tdir[w] : m_dir[w];
            end
        end
        if (obstacle != m_deb) begin
            if (m_debc == DEB - 1) begin m_deb = !m_deb; m_debc = 0; end
            else m_debc = m_debc + 1;
        end else begin
            m_debc = 0;
        end
        m_brake = (m_state != 3) ? 0 : ((m_brake < BMIN) ? m_brake + 1 : m_brake);
        m_cnt = (m_cnt + 1) % (1 << PWM_W);
        m_div = tick ? 0 : m_div + 1;
        m_state = nstate;
        for (int w = 0; w < 2; w++) begin
            m_duty[w] = nd[w]; m_dir[w] = ndir[w]; m_pwm[w] = np[w];
        end
    endtask

    // one clock: model advances on the edge, outputs settle by the following falling edge
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int i;
        start_move = 1'b1; track_state = 2'b11;
        for (i = 0; i < 40; i++) begin
            step();
            if (m_duty[0] == 8) break;
        end
        n_checks++;
        if (dut.u_left.duty_r !== 4'd8) begin
            n_fail++; $display("FAIL reset_setup_duty: got %0d want 8", dut.u_left.duty_r);
        end
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", mode); end
        n_checks++;
        if ({left_pwm, right_pwm} !== 2'b00) begin
            n_fail++; $display("FAIL reset_pwm: got %b%b want 00", left_pwm, right_pwm);
        end
        n_checks++;
        if ({left_dir, right_dir} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_dir: got %b %b want 00 00", left_dir, right_dir);
        end
        step(); step();
        start_move = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_idle_hold: got %b want 00", mode); end
        end
    endtask

    task automatic test_ramp_up();
        logic [3:0] last;
        logic [3:0] seq[$];
        bit saw_ramp;
        int hl, hr;
        last = 4'd0; saw_ramp = 1'b0;
        start_move = 1'b1; track_state = 2'b11;
        for (int i = 0; i < 60; i++) begin
            step();
            if (dut.u_left.duty_r !== last) begin seq.push_back(dut.u_left.duty_r); last = dut.u_left.duty_r; end
            if (mode == 2'b01) saw_ramp = 1'b1;
            if (mode == 2'b10) break;
        end
        n_checks++;
        if (!saw_ramp || mode !== 2'b10) begin
            n_fail++; $display("FAIL ramp_modes: saw_ramp=%0d mode=%b want 1 and 10", saw_ramp, mode);
        end
        n_checks++;
        if (seq.size() != 3 || seq[0] !== 4'd4 || seq[1] !== 4'd8 || seq[2] !== 4'd12) begin
            n_fail++; $display("FAIL ramp_duty_seq: got %p want 4 8 12", seq);
        end
        hl = 0; hr = 0;
        for (int i = 0; i < 16; i++) begin step(); hl += left_pwm; hr += right_pwm; end
        n_checks++;
        if (hl != 12 || hr != 12) begin n_fail++; $display("FAIL ramp_pwm_count: got %0d/%0d want 12/12", hl, hr); end
        n_checks++;
        if (left_dir !== 2'b10 || right_dir !== 2'b10) begin
            n_fail++; $display("FAIL ramp_dir: got %b %b want 10 10", left_dir, right_dir);
        end
    endtask

    task automatic test_turn();
        logic [3:0] last;
        logic [3:0] seq[$];
        bit saw_ramp;
        int hl, hr;
        last = dut.u_left.duty_r; saw_ramp = 1'b0;
        track_state = 2'b10;
        for (int i = 0; i < 60; i++) begin
            step();
            if (dut.u_left.duty_r !== last) begin seq.push_back(dut.u_left.duty_r); last = dut.u_left.duty_r; end
            if (mode == 2'b01) saw_ramp = 1'b1;
            if (saw_ramp && mode == 2'b10) break;
        end
        n_checks++;
        if (!saw_ramp || mode !== 2'b10) begin
            n_fail++; $display("FAIL turn_modes: saw_ramp=%0d mode=%b want 1 and 10", saw_ramp, mode);
        end
`ifndef REVERSE_PIVOT_EN
        n_checks++;
        if (seq.size() != 2 || seq[0] !== 4'd8 || seq[1] !== 4'd6) begin
            n_fail++; $display("FAIL turn_left_seq: got %p want 8 6", seq);
        end
`endif
        n_checks++;
        if (dut.u_right.duty_r !== 4'd12) begin
            n_fail++; $display("FAIL turn_right_duty: got %0d want 12", dut.u_right.duty_r);
        end
        hl = 0; hr = 0;
        for (int i = 0; i < 16; i++) begin step(); hl += left_pwm; hr += right_pwm; end
        n_checks++;
        if (hl != 6 || hr != 12) begin n_fail++; $display("FAIL turn_pwm_count: got %0d/%0d want 6/12", hl, hr); end
    endtask

    task automatic test_obstacle();
        bit saw_brake;
        int n_brake;
        track_state = 2'b11;
        for (int i = 0; i < 80; i++) begin step(); if (mode == 2'b10) break; end
        n_checks++;
        if (mode !== 2'b10) begin n_fail++; $display("FAIL obst_setup_run: got %b want 10", mode); end
        obstacle = 1'b1; step(); step(); obstacle = 1'b0;
        saw_brake = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (mode == 2'b11) saw_brake = 1'b1; end
        n_checks++;
        if (saw_brake) begin n_fail++; $display("FAIL obst_short_pulse: got brake want none"); end
        obstacle = 1'b1;
        for (int i = 0; i < 10; i++) begin step(); if (mode == 2'b11) break; end
        n_checks++;
        if (mode !== 2'b11) begin n_fail++; $display("FAIL obst_enter_brake: got %b want 11", mode); end
        n_checks++;
        if ({left_pwm, right_pwm} !== 2'b00 || {left_dir, right_dir} !== 4'b0000) begin
            n_fail++; $display("FAIL obst_brake_outputs: got pwm %b%b dir %b %b want 0 0 00 00",
                               left_pwm, right_pwm, left_dir, right_dir);
        end
        obstacle = 1'b0;
        n_brake = 1;
        for (int i = 0; i < 80; i++) begin step(); if (mode == 2'b11) n_brake++; else break; end
        n_checks++;
        if (n_brake < BMIN) begin n_fail++; $display("FAIL obst_brake_len: got %0d want >= %0d", n_brake, BMIN); end
        n_checks++;
        if (mode !== 2'b01) begin n_fail++; $display("FAIL obst_exit_ramp: got %b want 01", mode); end
        n_checks++;
        if (dut.u_left.duty_r !== 4'd0 || dut.u_right.duty_r !== 4'd0) begin
            n_fail++; $display("FAIL obst_exit_duty: got %0d/%0d want 0/0", dut.u_left.duty_r, dut.u_right.duty_r);
        end
    endtask

    task automatic test_stop_in_brake();
        int bad;
        obstacle = 1'b1;
        for (int i = 0; i < 20; i++) begin step(); if (mode == 2'b11) break; end
        n_checks++;
        if (mode !== 2'b11) begin n_fail++; $display("FAIL stop_setup_brake: got %b want 11", mode); end
        step(); step();
        start_move = 1'b0; obstacle = 1'b0;
        step();
        n_checks++;
        if (mode !== 2'b00) begin n_fail++; $display("FAIL stop_brake_idle: got %b want 00", mode); end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (mode !== 2'b00 || left_pwm !== 1'b0 || right_pwm !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL stop_idle_hold: got %0d bad cycles want 0", bad); end
    endtask

`ifdef REVERSE_PIVOT_EN
    task automatic test_pivot();
        logic [1:0] prev;
        logic [1:0] seq[$];
        logic [3:0] duty_at_flip;
        bit saw_ramp;
        int hl, hr;
        start_move = 1'b1; track_state = 2'b11;
        for (int i = 0; i < 80; i++) begin step(); if (mode == 2'b10) break; end
        n_checks++;
        if (mode !== 2'b10) begin n_fail++; $display("FAIL pivot_setup_run: got %b want 10", mode); end
        prev = left_dir; saw_ramp = 1'b0; duty_at_flip = 4'hF;
        track_state = 2'b10;
        for (int i = 0; i < 120; i++) begin
            step();
            if (left_dir !== prev) begin
                seq.push_back(left_dir);
                if (left_dir == 2'b01) duty_at_flip = dut.u_left.duty_r;
                prev = left_dir;
            end
            if (mode == 2'b01) saw_ramp = 1'b1;
            if (saw_ramp && mode == 2'b10) break;
        end
        n_checks++;
        if (seq.size() != 1 || seq[0] !== 2'b01) begin n_fail++; $display("FAIL pivot_dir_seq: got %p want 01", seq); end
        n_checks++;
        if (duty_at_flip !== 4'd0) begin n_fail++; $display("FAIL pivot_flip_duty: got %0d want 0", duty_at_flip); end
        hl = 0; hr = 0;
        for (int i = 0; i < 16; i++) begin step(); hl += left_pwm; hr += right_pwm; end
        n_checks++;
        if (hl != 6 || hr != 12) begin n_fail++; $display("FAIL pivot_pwm_count: got %0d/%0d want 6/12", hl, hr); end
        n_checks++;
        if (left_dir !== 2'b01 || right_dir !== 2'b10) begin
            n_fail++; $display("FAIL pivot_dirs: got %b %b want 01 10", left_dir, right_dir);
        end
    endtask
`endif

    task automatic test_random();
        int hold;
        reset = 1'b0; start_move = 1'b0; obstacle = 1'b0;
        step();
        reset = 1'b1;
        for (int seg = 0; seg < 900; seg++) begin
            start_move  = ($urandom_range(0, 7) != 0);
            track_state = 2'($urandom_range(0, 3));
            obstacle    = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                step();
                n_checks++;
                if (mode !== 2'(m_state)) begin n_fail++; $display("FAIL rand_mode: got %b want %0d", mode, m_state); end
                n_checks++;
                if (left_pwm !== 1'(m_pwm[0])) begin n_fail++; $display("FAIL rand_left_pwm: got %b want %0d", left_pwm, m_pwm[0]); end
                n_checks++;
                if (right_pwm !== 1'(m_pwm[1])) begin n_fail++; $display("FAIL rand_right_pwm: got %b want %0d", right_pwm, m_pwm[1]); end
                n_checks++;
                if (left_dir !== 2'(m_dir[0])) begin n_fail++; $display("FAIL rand_left_dir: got %b want %0d", left_dir, m_dir[0]); end
                n_checks++;
                if (right_dir !== 2'(m_dir[1])) begin n_fail++; $display("FAIL rand_right_dir: got %b want %0d", right_dir, m_dir[1]); end
            end
        end
    endtask

    initial begin
        model_reset();
        step(); step(); step();
        reset = 1'b1;
        step();
        test_reset();
        test_ramp_up();
        test_turn();
        test_obstacle();
        test_stop_in_brake();
`ifdef REVERSE_PIVOT_EN
        test_pivot();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/motion_scheduler.md
Name: motion_scheduler

Overview:
- Sequences the two drive motors from the line-tracker's 2-bit steering decision.
- Arbitrates between three requesters:
  - start/stop command (highest priority)
  - debounced obstacle request from the ultrasonic front end
  - tracker steering request (lowest priority)
- Converts the winning request into per-wheel direction and soft-ramped PWM duty.
- Sits between the tracker policy block and the motor driver pins.

Parameters:
- PWM_W, 10: PWM counter width; period = 2^PWM_W cycles.
- SPEED_FAST, 1000: outer-wheel / straight duty (counts, < 2^PWM_W).
- SPEED_SLOW, 600: inner-wheel duty during turns.
- RAMP_STEP, 8: duty increment/decrement per ramp tick.
- RAMP_DIV, 100000: clk cycles per ramp tick.
- OBST_DEB, 1000000: consecutive cycles `obstacle` must hold a level to change the debounced value.
- BRAKE_MIN, 10000000: minimum cycles spent in BRAKE.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- start_move, input, 1: level; 1 = motion enabled.
- track_state, input, 2: steering request. 00 stop, 01 turn right, 10 turn left, 11 straight.
- obstacle, input, 1: raw "object too close" flag.
- left_pwm, output, 1: left motor enable PWM.
- right_pwm, output, 1: right motor enable PWM.
- left_dir, output, 2: left H-bridge inputs. 10 forward, 01 reverse, 00 coast.
- right_dir, output, 2: right H-bridge inputs, same encoding.
- mode, output, 2: FSM state for display. 00 IDLE, 01 RAMP, 10 RUN, 11 BRAKE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM = IDLE; duty_l = duty_r = 0; pwm counter = 0; ramp divider = 0; debounce counter = 0; debounced obstacle = 0.
  - Outputs: left_pwm = right_pwm = 0, left_dir = right_dir = 00, mode = 00.
- Targets, from track_state:
  - 11: both wheels SPEED_FAST, forward.
  - 10: left wheel SPEED_SLOW, right wheel SPEED_FAST, forward.
  - 01: left wheel SPEED_FAST, right wheel SPEED_SLOW, forward.
  - 00: both 0, dir 00.
- PWM:
  - Free-running PWM_W-bit counter, wraps 2^PWM_W−1 → 0.
  - pwm_x = (cnt < duty_x), registered; one-cycle latency from a duty change.
  - duty 0 gives a constant 0 output.
- Ramp:
  - Every RAMP_DIV cycles, each duty moves toward its target by RAMP_STEP, saturating exactly at the target.
  - Unsigned compare; no overshoot or wrap.
  - A target change mid-ramp retargets on the next tick.
- Obstacle debounce:
  - Counter counts while raw obstacle ≠ debounced value; it clears whenever they match.
  - Debounced value flips when the counter reaches OBST_DEB.
- FSM, priority start_move > obstacle > tracker:
  - IDLE: duties forced to 0. start_move=1 → RAMP.
  - RAMP: duties ramping. Both duties equal their targets → RUN.
  - RUN: follows tracker targets; a target change → RAMP.
  - Any state except IDLE, start_move=0: → IDLE in the same cycle, duties zeroed immediately (no ramp down).
  - RAMP or RUN, debounced obstacle rises: → BRAKE; duties zeroed immediately, dirs 00, BRAKE timer cleared.
  - BRAKE: leave only when timer ≥ BRAKE_MIN and debounced obstacle = 0 → RAMP, ramping from 0.
- Simultaneous start_move fall and obstacle rise: IDLE wins.
- track_state = 00 in RUN: ramps down to 0 and stays in RUN, dirs 00 once duty reaches 0.

Optional Feature:
- REVERSE_PIVOT_EN defined:
  - During a turn, the inner wheel target becomes SPEED_SLOW with dir = reverse (01).
  - A dir change on a wheel first ramps that wheel to 0, then flips dir, then ramps up.
- Undefined: inner wheel always runs forward at SPEED_SLOW, as in Behaviour.

Decomposition:
- Shared package holds:
  - steering encodings (STOP, RIGHT, LEFT, STRAIGHT)
  - dir encodings (FWD, REV, COAST)
  - mode encodings
- One sub-module, `pwm_ramp_channel`, instantiated twice (one per wheel). It contains the duty register, ramp saturation and PWM compare, and takes the shared counter and ramp tick as inputs.
- Debounce and FSM stay in the top level.

Test Plan:
All tests use PWM_W=4, SPEED_FAST=12, SPEED_SLOW=6, RAMP_STEP=4, RAMP_DIV=2, OBST_DEB=3, BRAKE_MIN=10.
1. Reset low mid-run with duty 8 → all outputs 0 and mode=00 in the same cycle; after release, stays IDLE until start_move.
2. start_move=1, track_state=11 → duty 0→4→8→12 on successive ramp ticks; mode 01 then 10; pwm high exactly 12 of 16 cycles.
3. In RUN, track_state 11→10 → left duty steps 12→8→6 (saturates at 6), right stays 12.
4. obstacle pulse of 2 cycles → no BRAKE. Pulse of 3+ cycles → mode=11 and pwm 0 next cycle. Release → exit no earlier than 10 cycles after entry, then ramp from 0.
5. start_move falls during BRAKE, in the same cycle obstacle clears → mode=00 and stays 00.
6. REVERSE_PIVOT_EN, turn left from straight → left duty ramps to 0, left_dir 10→01, then ramps to 6.
